// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the bottle-flip game controller.
//   - state_t        : FSM state encoding. The low three bits are what the
//                      controller reports on state_o. The single-cycle states
//                      JUDGE and GEN share low bits with FLY and SHIFT, so they
//                      show up as the animation phase they sit inside.
//   - LFSR_TAPS      : Galois tap mask of the right-shifting platform LFSR.
//   - width_map()    : maps five random bits to a platform half-width 4..7.
//   - bcd_digit_add(): one BCD digit add with carry in/out.
// -----------------------------------------------------------------------------
package game_pkg;

   typedef enum logic [3:0] {
      ST_INIT   = 4'd0,
      ST_WAIT   = 4'd1,
      ST_CHARGE = 4'd2,
      ST_FLY    = 4'd3,
      ST_SHIFT  = 4'd4,
      ST_FALL   = 4'd5,
      ST_OVER   = 4'd6,
      ST_JUDGE  = 4'd11,
      ST_GEN    = 4'd12
   } state_t;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   function automatic logic [7:0] width_map(input logic [4:0] r);
      if (r < 5'd5)       return 8'd4;
      else if (r < 5'd16) return 8'd5;
      else if (r < 5'd27) return 8'd6;
      else                return 8'd7;
   endfunction

   // Returns {carry_out, digit}. Inputs are valid BCD digits, so the raw sum
   // is at most 19 and a single -10 correction is enough.
   function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                                input logic [3:0] b,
                                                input logic       cin);
      logic [4:0] s;
      s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
      else          return {1'b0, s[3:0]};
   endfunction

endpackage

// File: rtl/bcd_sat_adder.sv
// -----------------------------------------------------------------------------
// bcd_sat_adder
// Adds a small binary addend (0..15) to a DIGITS-wide BCD number. If the
// result does not fit, the output clamps to all nines instead of wrapping.
//   a      in  4*DIGITS  BCD operand
//   addend in  4         binary addend
//   sum    out 4*DIGITS  saturated BCD sum
// -----------------------------------------------------------------------------
module bcd_sat_adder
   import game_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic [4*DIGITS-1:0] a,
   input  logic [3:0]          addend,
   output logic [4*DIGITS-1:0] sum
);

   // Addend converted to BCD, padded one digit beyond the operand so a tens
   // digit that has nowhere to go (DIGITS == 1) can be detected as overflow.
   logic [4*DIGITS+3:0] b_ext;
   logic [4*DIGITS-1:0] raw;
   logic                carry;
   logic [4:0]          d;

   always_comb begin
      b_ext = '0;
      if (addend > 4'd9) begin
         b_ext[3:0] = addend - 4'd10;
         b_ext[7:4] = 4'd1;
      end else begin
         b_ext[3:0] = addend;
      end
      raw   = '0;
      carry = 1'b0;
      d     = '0;
      for (int i = 0; i < DIGITS; i++) begin
         d              = bcd_digit_add(a[4*i +: 4], b_ext[4*i +: 4], carry);
         raw[4*i +: 4]  = d[3:0];
         carry          = d[4];
      end
      if (carry || (b_ext[4*DIGITS +: 4] != 4'd0))
         sum = {DIGITS{4'h9}};
      else
         sum = raw;
   end

endmodule

// File: rtl/game_ctrl_n.sv
// -----------------------------------------------------------------------------
// game_ctrl_n
// Bottle-flip game controller: owns the platform queue (filled from a free
// running LFSR), measures jump charge while the button is held, judges the
// landing, and keeps a saturating BCD score, a perfect-combo and lives.
// All game progress is paced by the frame enable `tick`.
//   clk, restart     clock, asynchronous active-high reset
//   tick             one-cycle frame enable
//   press            jump button level (synchronised)
//   sq_width         platform half-widths, entry i at [8i+:8]
//   sq_dist          gap from platform i to i+1
//   sq_layout        direction of gap i (0 right, 1 left)
//   sq_color         colour scheme per platform
//   charge           current / last jump charge
//   fly_step         flight animation progress
//   shift_step       scroll animation progress
//   score            BCD score
//   lives, combo     remaining lives, current perfect combo
//   perfect          one-cycle pulse on a perfect landing
//   state_o          low three bits of the FSM state
// The player stands on queue entry 1 and jumps to entry 2.
// -----------------------------------------------------------------------------
module game_ctrl_n
   import game_pkg::*;
#(
   parameter int          NUM_SQ       = 4,
   parameter int          SCORE_DIGITS = 4,
   parameter int          LIVES        = 3,
   parameter int          COMBO_MAX    = 4,
   parameter int          DIST_MIN     = 13,
   parameter int          DIST_RBITS   = 3,
   parameter int          FLY_STEPS    = 16,
   parameter int          SHIFT_STEPS  = 16,
   parameter int          FALL_TICKS   = 32,
   parameter logic [31:0] LFSR_SEED    = 32'h346B_4A5C
) (
   input  logic                            clk,
   input  logic                            restart,
   input  logic                            tick,
   input  logic                            press,
   output logic [NUM_SQ*8-1:0]             sq_width,
   output logic [(NUM_SQ-1)*8-1:0]         sq_dist,
   output logic [NUM_SQ-2:0]               sq_layout,
   output logic [NUM_SQ-1:0]               sq_color,
   output logic [7:0]                      charge,
   output logic [$clog2(FLY_STEPS):0]      fly_step,
   output logic [$clog2(SHIFT_STEPS):0]    shift_step,
   output logic [4*SCORE_DIGITS-1:0]       score,
   output logic [2:0]                      lives,
   output logic [2:0]                      combo,
   output logic                            perfect,
   output logic [2:0]                      state_o
);

   localparam int         B      = 1;
   localparam int         FW     = $clog2(FLY_STEPS) + 1;
   localparam int         SW     = $clog2(SHIFT_STEPS) + 1;
   localparam int         LW     = $clog2(FALL_TICKS) + 1;
   localparam int         IW     = $clog2(NUM_SQ) + 1;
   localparam logic [7:0] RMASK  = 8'((1 << DIST_RBITS) - 1);

   state_t                 state;
   logic [31:0]            lfsr;
   logic [7:0]             w_q [NUM_SQ];
   logic [7:0]             d_q [NUM_SQ-1];
   logic [NUM_SQ-2:0]      l_q;
   logic [NUM_SQ-1:0]      c_q;
   logic [IW-1:0]          fill_idx;
   logic [LW-1:0]          fall_cnt;
   // Set once the button has been seen released in WAIT; a jump may only
   // start from a fresh press, never from a press held over from before.
   logic                   armed;

   logic [31:0]            lfsr_nxt;
   logic [7:0]             new_width;
   logic [7:0]             new_gap;
   logic                   new_layout;
   logic [7:0]             err;
   logic                   is_perfect;
   logic                   is_hit;
   logic [2:0]             combo_inc;
   logic [3:0]             addend;
   logic [4*SCORE_DIGITS-1:0] score_sum;

   assign state_o   = state[2:0];
   assign sq_layout = l_q;
   assign sq_color  = c_q;

   for (genvar g = 0; g < NUM_SQ; g++) begin : g_width
      assign sq_width[8*g +: 8] = w_q[g];
   end
   for (genvar g = 0; g < NUM_SQ-1; g++) begin : g_dist
      assign sq_dist[8*g +: 8] = d_q[g];
   end

   always_comb begin
      lfsr_nxt   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
      new_width  = width_map(lfsr[4:0]);
      new_gap    = 8'(DIST_MIN) + ({5'd0, lfsr[12:10]} & RMASK);
      // High nibble values keep the scroll direction, otherwise it turns.
      new_layout = (lfsr[3:0] > 4'd13) ? l_q[NUM_SQ-2] : ~l_q[NUM_SQ-2];
      err        = (charge >= d_q[B]) ? (charge - d_q[B]) : (d_q[B] - charge);
      is_perfect = (err == 8'd0);
      is_hit     = (err <= w_q[B+1]);
      combo_inc  = (combo >= 3'(COMBO_MAX)) ? 3'(COMBO_MAX) : combo + 3'd1;
      addend     = is_perfect ? {combo_inc, 1'b0} : 4'd1;
   end

   bcd_sat_adder #(.DIGITS(SCORE_DIGITS)) u_add (
      .a      (score),
      .addend (addend),
      .sum    (score_sum)
   );

   always_ff @(posedge clk or posedge restart) begin
      if (restart) begin
         state      <= ST_INIT;
         lfsr       <= LFSR_SEED;
         for (int i = 0; i < NUM_SQ; i++)   w_q[i] <= '0;
         for (int i = 0; i < NUM_SQ-1; i++) d_q[i] <= '0;
         l_q        <= '0;
         c_q        <= '0;
         fill_idx   <= '0;
         fall_cnt   <= '0;
         armed      <= 1'b0;
         charge     <= '0;
         fly_step   <= '0;
         shift_step <= '0;
         score      <= '0;
         lives      <= 3'(LIVES);
         combo      <= '0;
         perfect    <= 1'b0;
      end else begin
         lfsr    <= lfsr_nxt;
         perfect <= 1'b0;
         if (state != ST_WAIT) armed <= 1'b0;

         case (state)
            ST_INIT: begin
               if (fill_idx == IW'(NUM_SQ)) begin
                  fill_idx <= '0;
                  state    <= ST_WAIT;
               end else begin
                  for (int i = 0; i < NUM_SQ; i++) begin
                     if (fill_idx == IW'(i)) begin
                        w_q[i] <= new_width;
                        c_q[i] <= lfsr[20];
                     end
                  end
                  for (int i = 0; i < NUM_SQ-1; i++) begin
                     if (fill_idx == IW'(i)) begin
                        d_q[i] <= new_gap;
                        l_q[i] <= lfsr[24];
                     end
                  end
                  fill_idx <= fill_idx + IW'(1);
               end
            end

            ST_WAIT: begin
               if (!press) begin
                  armed <= 1'b1;
               end else if (tick && armed) begin
                  armed  <= 1'b0;
                  charge <= 8'd1;
                  state  <= ST_CHARGE;
               end
            end

            ST_CHARGE: begin
               if (tick) begin
                  if (press) begin
                     if (charge != 8'hFF) charge <= charge + 8'd1;
                  end else begin
                     fly_step <= '0;
                     state    <= ST_FLY;
                  end
               end
            end

            ST_FLY: begin
               if (tick) begin
                  fly_step <= fly_step + FW'(1);
                  if (fly_step == FW'(FLY_STEPS - 1)) state <= ST_JUDGE;
               end
            end

            ST_JUDGE: begin
               if (is_perfect) begin
                  combo   <= combo_inc;
                  score   <= score_sum;
                  perfect <= 1'b1;
                  state   <= ST_SHIFT;
               end else if (is_hit) begin
                  combo   <= '0;
                  score   <= score_sum;
                  state   <= ST_SHIFT;
               end else begin
                  combo    <= '0;
                  fall_cnt <= '0;
                  state    <= ST_FALL;
               end
            end

            ST_SHIFT: begin
               if (tick) begin
                  if (shift_step == SW'(SHIFT_STEPS - 1)) begin
                     shift_step <= '0;
                     state      <= ST_GEN;
                  end else begin
                     shift_step <= shift_step + SW'(1);
                  end
               end
            end

            ST_GEN: begin
               for (int i = 0; i < NUM_SQ-1; i++) w_q[i] <= w_q[i+1];
               w_q[NUM_SQ-1] <= new_width;
               for (int i = 0; i < NUM_SQ-2; i++) d_q[i] <= d_q[i+1];
               d_q[NUM_SQ-2] <= new_gap;
               l_q      <= {new_layout, l_q[NUM_SQ-2:1]};
               c_q      <= {lfsr[20], c_q[NUM_SQ-1:1]};
               charge   <= '0;
               fly_step <= '0;
               state    <= ST_WAIT;
            end

            ST_FALL: begin
               if (tick) begin
                  if (fall_cnt == LW'(FALL_TICKS - 1)) begin
                     fall_cnt <= '0;
                     lives    <= lives - 3'd1;
                     // Queue is left alone so the same gap is retried.
                     state    <= (lives == 3'd1) ? ST_OVER : ST_WAIT;
                  end else begin
                     fall_cnt <= fall_cnt + LW'(1);
                  end
               end
            end

            ST_OVER: begin
            end

            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_game_ctrl_n.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl_n
// Self-checking bench for game_ctrl_n. A second instance with a one-digit
// score shares all inputs to exercise score saturation. A bench-side LFSR and
// queue model predict the platforms; landing outcomes are pushed to a
// scoreboard queue when a jump is released and compared when the DUT lands.
// -----------------------------------------------------------------------------
module tb_game_ctrl_n;

   localparam int          NUM_SQ = 4;
   localparam logic [31:0] SEED   = 32'h346B_4A5C;
   localparam logic [31:0] TAPS   = 32'h8020_0003;
   localparam logic [2:0]  S_INIT = 3'd0, S_WAIT = 3'd1, S_CHARGE = 3'd2,
                           S_FLY = 3'd3, S_SHIFT = 3'd4, S_FALL = 3'd5,
                           S_OVER = 3'd6;
   localparam int          EXP_W  = 27;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic restart, tick, press;
   always #5 clk = ~clk;

   logic [NUM_SQ*8-1:0]     sq_width,   u1_sq_width;
   logic [(NUM_SQ-1)*8-1:0] sq_dist,    u1_sq_dist;
   logic [NUM_SQ-2:0]       sq_layout,  u1_sq_layout;
   logic [NUM_SQ-1:0]       sq_color,   u1_sq_color;
   logic [7:0]              charge,     u1_charge;
   logic [4:0]              fly_step,   u1_fly_step;
   logic [4:0]              shift_step, u1_shift_step;
   logic [15:0]             score;
   logic [3:0]              u1_score;
   logic [2:0]              lives,      u1_lives;
   logic [2:0]              combo,      u1_combo;
   logic                    perfect,    u1_perfect;
   logic [2:0]              state_o,    u1_state_o;

   game_ctrl_n u_dut (
      .clk(clk), .restart(restart), .tick(tick), .press(press),
      .sq_width(sq_width), .sq_dist(sq_dist), .sq_layout(sq_layout),
      .sq_color(sq_color), .charge(charge), .fly_step(fly_step),
      .shift_step(shift_step), .score(score), .lives(lives), .combo(combo),
      .perfect(perfect), .state_o(state_o)
   );

   game_ctrl_n #(.SCORE_DIGITS(1)) u_dut1 (
      .clk(clk), .restart(restart), .tick(tick), .press(press),
      .sq_width(u1_sq_width), .sq_dist(u1_sq_dist), .sq_layout(u1_sq_layout),
      .sq_color(u1_sq_color), .charge(u1_charge), .fly_step(u1_fly_step),
      .shift_step(u1_shift_step), .score(u1_score), .lives(u1_lives),
      .combo(u1_combo), .perfect(u1_perfect), .state_o(u1_state_o)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
   endfunction

   function automatic int wmap(input logic [4:0] r);
      if (r < 5)  return 4;
      if (r < 16) return 5;
      if (r < 27) return 6;
      return 7;
   endfunction

   function automatic int gap_of(input logic [31:0] v);
      return 13 + int'(v[12:10]);
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   logic [31:0] m_lfsr, m_used;
   always @(posedge clk or posedge restart) begin
      if (restart) begin
         m_lfsr <= SEED;
         m_used <= '0;
      end else begin
         m_used <= m_lfsr;
         m_lfsr <= lfsr_step(m_lfsr);
      end
   end

   int                m_w [NUM_SQ];
   int                m_d [NUM_SQ-1];
   logic [NUM_SQ-2:0] m_l;
   logic [NUM_SQ-1:0] m_c;
   int                m_score, m_score1, m_combo, m_lives, m_nperf;
   int                n_perf = 0;

   // ---------------- scoreboard ----------------
   logic [EXP_W-1:0] exp_q[$];

   // Monitor: keeps the queue model in step with INIT fills and GEN cycles,
   // and compares landing results against the scoreboard.
   initial begin : monitor
      logic [2:0]       prev_st;
      logic [EXP_W-1:0] e;
      logic             nl;
      int               fill_cnt;
      prev_st  = S_INIT;
      fill_cnt = 0;
      forever begin
         @(negedge clk);
         if (restart) begin
            fill_cnt = 0;
            prev_st  = S_INIT;
         end else begin
            if (perfect) n_perf++;
            if (prev_st == S_INIT && fill_cnt < NUM_SQ) begin
               m_w[fill_cnt] = wmap(m_used[4:0]);
               m_c[fill_cnt] = m_used[20];
               if (fill_cnt < NUM_SQ-1) begin
                  m_d[fill_cnt] = gap_of(m_used);
                  m_l[fill_cnt] = m_used[24];
               end
               fill_cnt++;
            end
            if (prev_st == S_SHIFT && state_o == S_WAIT) begin
               nl = (m_used[3:0] > 4'd13) ? m_l[NUM_SQ-2] : ~m_l[NUM_SQ-2];
               for (int i = 0; i < NUM_SQ-1; i++) m_w[i] = m_w[i+1];
               m_w[NUM_SQ-1] = wmap(m_used[4:0]);
               for (int i = 0; i < NUM_SQ-2; i++) m_d[i] = m_d[i+1];
               m_d[NUM_SQ-2] = gap_of(m_used);
               m_l = {nl, m_l[NUM_SQ-2:1]};
               m_c = {m_used[20], m_c[NUM_SQ-1:1]};
            end
            if (prev_st == S_FLY && (state_o == S_SHIFT || state_o == S_FALL)) begin
               if (exp_q.size() == 0) begin
                  check("sb_pending", exp_q.size(), 1);
               end else begin
                  e = exp_q.pop_front();
                  check("land_state",   state_o,  e[26:24]);
                  check("land_perfect", perfect,  e[23]);
                  check("land_combo",   combo,    e[22:20]);
                  check("land_score",   score,    e[19:4]);
                  check("land_score1",  u1_score, e[3:0]);
               end
            end
            prev_st = state_o;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic frame(input logic p);
      @(negedge clk); #1;
      press = p;
      tick  = 1'b1;
      @(negedge clk); #1;
      tick  = 1'b0;
   endtask

   task automatic settle();
      for (int i = 0; i < 400; i++) begin
         if (state_o == S_WAIT || state_o == S_OVER) return;
         frame(1'b0);
      end
      check("settle_timeout", state_o, S_WAIT);
   endtask

   task automatic check_queue(input string where);
      for (int i = 0; i < NUM_SQ; i++) begin
         check($sformatf("%s_w%0d", where, i), sq_width[8*i +: 8], m_w[i]);
         check($sformatf("%s_c%0d", where, i), sq_color[i], m_c[i]);
      end
      for (int i = 0; i < NUM_SQ-1; i++) begin
         check($sformatf("%s_d%0d", where, i), sq_dist[8*i +: 8], m_d[i]);
         check($sformatf("%s_l%0d", where, i), sq_layout[i], m_l[i]);
      end
   endtask

   task automatic wait_init();
      int cnt;
      cnt = 0;
      while (state_o != S_WAIT && cnt < 50) begin
         @(negedge clk); #1;
         cnt++;
      end
      check("init_cycles", cnt, NUM_SQ + 1);
   endtask

   task automatic do_restart();
      @(negedge clk); #2;
      restart = 1'b1;
      #1;
      check("rst_state",  state_o,    S_INIT);
      check("rst_score",  score,      0);
      check("rst_lives",  lives,      3);
      check("rst_combo",  combo,      0);
      check("rst_charge", charge,     0);
      check("rst_fly",    fly_step,   0);
      check("rst_shift",  shift_step, 0);
      check("rst_queue",  32'(|{sq_width, sq_dist, sq_layout, sq_color}), 0);
      m_score  = 0;
      m_score1 = 0;
      m_combo  = 0;
      m_lives  = 3;
      @(negedge clk); #1;
      restart = 1'b0;
      wait_init();
   endtask

   // Hold the button for n ticks starting from WAIT, then release.
   task automatic jump(input int n);
      int         d1, w2, err, add;
      logic [2:0] st_exp;
      logic       perf;
      press = 1'b0;
      @(negedge clk); #1;
      d1 = m_d[1];
      w2 = m_w[2];
      repeat (n) frame(1'b1);
      err  = (n > d1) ? n - d1 : d1 - n;
      perf = 1'b0;
      add  = 0;
      if (err == 0) begin
         m_combo = (m_combo + 1 > 4) ? 4 : m_combo + 1;
         add     = 2 * m_combo;
         perf    = 1'b1;
         m_nperf++;
         st_exp  = S_SHIFT;
      end else if (err <= w2) begin
         m_combo = 0;
         add     = 1;
         st_exp  = S_SHIFT;
      end else begin
         m_combo = 0;
         m_lives--;
         st_exp  = S_FALL;
      end
      m_score  = (m_score + add > 9999) ? 9999 : m_score + add;
      m_score1 = (m_score1 + add > 9) ? 9 : m_score1 + add;
      exp_q.push_back({st_exp, perf, 3'(m_combo), to_bcd(m_score), 4'(m_score1)});
      frame(1'b0);
      settle();
      check("after_state", state_o, (m_lives == 0) ? S_OVER : S_WAIT);
      check("after_lives", lives,   m_lives);
      check("after_nperf", n_perf,  m_nperf);
      check("after_charge", charge, (st_exp == S_FALL) ? n : 0);
      check_queue("q");
   endtask

   // ---------------- main sequence ----------------
   initial begin : watchdog
      #300000;
      $display("FAIL watchdog state=%0d", state_o);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int old_d2, last_n;
      restart = 1'b1;
      tick    = 1'b0;
      press   = 1'b0;
      m_score = 0; m_score1 = 0; m_combo = 0; m_lives = 3; m_nperf = 0;
      @(negedge clk); #1;
      check("por_state", state_o, S_INIT);
      check("por_lives", lives,   3);
      check("por_score", score,   0);
      @(negedge clk); #1;
      restart = 1'b0;
      wait_init();
      check("init_lives", lives, 3);
      check("init_score", score, 0);
      for (int i = 0; i < NUM_SQ; i++)
         check("width_range", 32'(sq_width[8*i +: 8] >= 4 && sq_width[8*i +: 8] <= 7), 1);
      for (int i = 0; i < NUM_SQ-1; i++)
         check("dist_range", 32'(sq_dist[8*i +: 8] >= 13 && sq_dist[8*i +: 8] <= 20), 1);
      check_queue("init");

      // Perfect, then the old gap 2 scrolls into gap 1.
      old_d2 = m_d[2];
      jump(m_d[1]);
      check("dist_scrolled", sq_dist[15:8], old_d2);
      check("score_p1", score, 16'h0002);
      // Two more perfects then a near hit: 2, 6, 12, 13.
      jump(m_d[1]);
      jump(m_d[1]);
      jump(m_d[1] + 1);
      check("score_13", score, 16'h0013);
      check("combo_0",  combo, 0);
      check("score1_sat", u1_score, 4'h9);

      // Restart in the middle of a flight.
      press = 1'b0;
      @(negedge clk); #1;
      repeat (3) frame(1'b1);
      frame(1'b0);
      repeat (3) frame(1'b0);
      check("mid_fly_state", state_o, S_FLY);
      do_restart();
      check_queue("rst1");

      // Restart while charging with the button held through it.
      press = 1'b0;
      @(negedge clk); #1;
      repeat (2) frame(1'b1);
      check("mid_charge_state", state_o, S_CHARGE);
      do_restart();
      repeat (3) frame(1'b1);
      check("held_press_state",  state_o, S_WAIT);
      check("held_press_charge", charge,  0);
      jump(m_d[1]);
      check("score_after_rst", score, 16'h0002);

      // Three misses: lives run out, queue never changes.
      for (int k = 0; k < 3; k++) begin
         last_n = m_d[1] + m_w[2] + 1;
         jump(last_n);
      end
      check("over_lives", lives, 0);
      press = 1'b0;
      @(negedge clk); #1;
      repeat (3) frame(1'b1);
      frame(1'b0);
      check("over_state",  state_o, S_OVER);
      check("over_charge", charge,  last_n);
      check("over_score",  score,   16'h0002);
      check("sb_drained",  exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
